mpu6050_i2c_target: RTL and testbench

I2C target (slave) that emulates the MPU6050 register map at address 0x68 and answers the reads and writes our MPU6050 master issues. It gives the master-side read and init path a cycle-accurate counterpart in simulation and in FPGA loopback. It also serves as a drop-in sensor stand-in when the board has no MPU6050 fitted. Sensor values come from parallel input ports; configuration writes leave the block as a register-write strobe.

---
 rtl/mpu6050_i2c_target.sv | 306 ++++++++++++++++++++++++++++++
 tb/tb_mpu6050_i2c_target.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mpu6050_i2c_target.sv
`timescale 1ns/1ps
// mpu6050_i2c_target
// I2C target that answers at SLAVE_ADDR with the MPU6050 register map.
// Sensor values come in on parallel ports and are snapshotted at the start of
// every read so that multi-byte bursts are coherent. Configuration writes are
// reported through reg_wr / reg_wr_addr / reg_wr_data.
// Build option: define MPU_TARGET_GLITCH_FILTER_EN to insert a 3-sample
// majority filter behind each input synchronizer (rejects 1-clk pulses and
// adds 2 clk of latency to every bus event).
module mpu6050_i2c_target #(
  parameter logic [6:0] SLAVE_ADDR   = 7'h68,
  parameter logic [7:0] WHO_AM_I_VAL = 8'h68
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        SCL,
  inout  wire         SDA,
  input  logic [15:0] GYROX,
  input  logic [15:0] GYROY,
  input  logic [15:0] GYROZ,
  input  logic [15:0] ACCELX,
  input  logic [15:0] ACCELY,
  input  logic [15:0] ACCELZ,
  output logic        reg_wr,
  output logic [7:0]  reg_wr_addr,
  output logic [7:0]  reg_wr_data,
  output logic [7:0]  pwr_mgmt,
  output logic        busy
);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_REG, S_REG_ACK,
    S_WDATA, S_WDATA_ACK, S_RDATA, S_RDATA_ACK, S_IGNORE
  } state_t;

  logic [1:0]  scl_sync, sda_sync;
  logic        scl_in, sda_in;
  logic        scl_prev, sda_prev;
  logic        scl_rise, scl_fall, start_det, stop_det;

  state_t      state;
  logic [3:0]  bit_cnt;
  logic [6:0]  shift;
  logic [7:0]  shift_next;
  logic [7:0]  ptr;
  logic        rw;
  logic        ack_phase;
  logic        sda_oe;
  logic [7:0]  cfg [4];
  logic [15:0] shadow [6];
  logic [7:0]  rd_byte;
  logic [2:0]  bit_idx;
  logic [1:0]  cfg_idx;
  logic        ptr_is_cfg;

  // Open-drain output: only ever pull low or release.
  assign SDA = sda_oe ? 1'b0 : 1'bz;

  // Two-flop synchronizers on both bus pins; idle bus level is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
    end else begin
      scl_sync <= {scl_sync[0], SCL};
      sda_sync <= {sda_sync[0], SDA};
    end
  end

`ifdef MPU_TARGET_GLITCH_FILTER_EN
  logic [1:0] scl_hist, sda_hist;

  // Majority vote over the current and two previous synchronized samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_hist <= 2'b11;
      sda_hist <= 2'b11;
      scl_in   <= 1'b1;
      sda_in   <= 1'b1;
    end else begin
      scl_hist <= {scl_hist[0], scl_sync[1]};
      sda_hist <= {sda_hist[0], sda_sync[1]};
      scl_in   <= (scl_sync[1] & scl_hist[0]) | (scl_sync[1] & scl_hist[1]) |
                  (scl_hist[0] & scl_hist[1]);
      sda_in   <= (sda_sync[1] & sda_hist[0]) | (sda_sync[1] & sda_hist[1]) |
                  (sda_hist[0] & sda_hist[1]);
    end
  end
`else
  assign scl_in = scl_sync[1];
  assign sda_in = sda_sync[1];
`endif

  // Previous-sample register for edge and bus-condition detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_prev <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      scl_prev <= scl_in;
      sda_prev <= sda_in;
    end
  end

  assign scl_rise   = scl_in & ~scl_prev;
  assign scl_fall   = ~scl_in & scl_prev;
  assign start_det  = scl_in & scl_prev & sda_prev & ~sda_in;
  assign stop_det   = scl_in & scl_prev & ~sda_prev & sda_in;
  assign shift_next = {shift, sda_in};
  assign bit_idx    = 3'd7 - bit_cnt[2:0];
  assign cfg_idx    = ptr[1:0] - 2'd1;
  assign ptr_is_cfg = (ptr >= 8'h19) && (ptr <= 8'h1C);

  // Read-side register map, addressed by the current pointer.
  always_comb begin
    rd_byte = 8'h00;
    case (ptr)
      8'h19:   rd_byte = cfg[0];
      8'h1A:   rd_byte = cfg[1];
      8'h1B:   rd_byte = cfg[2];
      8'h1C:   rd_byte = cfg[3];
      8'h3B:   rd_byte = shadow[0][15:8];
      8'h3C:   rd_byte = shadow[0][7:0];
      8'h3D:   rd_byte = shadow[1][15:8];
      8'h3E:   rd_byte = shadow[1][7:0];
      8'h3F:   rd_byte = shadow[2][15:8];
      8'h40:   rd_byte = shadow[2][7:0];
      8'h43:   rd_byte = shadow[3][15:8];
      8'h44:   rd_byte = shadow[3][7:0];
      8'h45:   rd_byte = shadow[4][15:8];
      8'h46:   rd_byte = shadow[4][7:0];
      8'h47:   rd_byte = shadow[5][15:8];
      8'h48:   rd_byte = shadow[5][7:0];
      8'h6B:   rd_byte = pwr_mgmt;
      8'h75:   rd_byte = WHO_AM_I_VAL;
      default: rd_byte = 8'h00;
    endcase
  end

  // Protocol FSM plus register file; START/STOP override every state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      bit_cnt     <= 4'd0;
      shift       <= 7'd0;
      ptr         <= 8'h00;
      rw          <= 1'b0;
      ack_phase   <= 1'b0;
      sda_oe      <= 1'b0;
      reg_wr      <= 1'b0;
      reg_wr_addr <= 8'h00;
      reg_wr_data <= 8'h00;
      pwr_mgmt    <= 8'h40;
      busy        <= 1'b0;
      for (int i = 0; i < 4; i++) cfg[i] <= 8'h00;
      for (int i = 0; i < 6; i++) shadow[i] <= 16'h0000;
    end else begin
      reg_wr <= 1'b0;
      if (start_det) begin
        state     <= S_ADDR;
        bit_cnt   <= 4'd0;
        ack_phase <= 1'b0;
        sda_oe    <= 1'b0;
        busy      <= 1'b1;
      end else if (stop_det) begin
        state     <= S_IDLE;
        bit_cnt   <= 4'd0;
        ack_phase <= 1'b0;
        sda_oe    <= 1'b0;
        busy      <= 1'b0;
      end else begin
        case (state)
          S_ADDR: begin
            if (scl_rise) begin
              shift <= shift_next[6:0];
              if (bit_cnt == 4'd7) begin
                bit_cnt <= 4'd0;
                if (shift_next[7:1] == SLAVE_ADDR) begin
                  rw        <= shift_next[0];
                  ack_phase <= 1'b0;
                  state     <= S_ADDR_ACK;
                  // Freeze sensor values for the whole read burst.
                  if (shift_next[0]) begin
                    shadow[0] <= ACCELX;
                    shadow[1] <= ACCELY;
                    shadow[2] <= ACCELZ;
                    shadow[3] <= GYROX;
                    shadow[4] <= GYROY;
                    shadow[5] <= GYROZ;
                  end
                end else begin
                  state <= S_IGNORE;
                end
              end else begin
                bit_cnt <= bit_cnt + 4'd1;
              end
            end
          end
          S_ADDR_ACK: begin
            if (scl_fall) begin
              if (!ack_phase) begin
                sda_oe    <= 1'b1;
                ack_phase <= 1'b1;
              end else begin
                ack_phase <= 1'b0;
                bit_cnt   <= 4'd0;
                if (rw) begin
                  state  <= S_RDATA;
                  sda_oe <= ~rd_byte[7];
                end else begin
                  state  <= S_REG;
                  sda_oe <= 1'b0;
                end
              end
            end
          end
          S_REG: begin
            if (scl_rise) begin
              shift <= shift_next[6:0];
              if (bit_cnt == 4'd7) begin
                bit_cnt   <= 4'd0;
                ptr       <= shift_next;
                ack_phase <= 1'b0;
                state     <= S_REG_ACK;
              end else begin
                bit_cnt <= bit_cnt + 4'd1;
              end
            end
          end
          S_REG_ACK, S_WDATA_ACK: begin
            if (scl_fall) begin
              if (!ack_phase) begin
                sda_oe    <= 1'b1;
                ack_phase <= 1'b1;
              end else begin
                ack_phase <= 1'b0;
                sda_oe    <= 1'b0;
                bit_cnt   <= 4'd0;
                state     <= S_WDATA;
              end
            end
          end
          S_WDATA: begin
            if (scl_rise) begin
              shift <= shift_next[6:0];
              if (bit_cnt == 4'd7) begin
                bit_cnt     <= 4'd0;
                reg_wr      <= 1'b1;
                reg_wr_addr <= ptr;
                reg_wr_data <= shift_next;
                ptr         <= ptr + 8'd1;
                ack_phase   <= 1'b0;
                state       <= S_WDATA_ACK;
                if (ptr_is_cfg) begin
                  cfg[cfg_idx] <= shift_next;
                end else if (ptr == 8'h6B) begin
                  // Device-reset bit restores all writable registers and self-clears.
                  if (shift_next[7]) begin
                    pwr_mgmt <= 8'h40;
                    for (int i = 0; i < 4; i++) cfg[i] <= 8'h00;
                  end else begin
                    pwr_mgmt <= {1'b0, shift_next[6:0]};
                  end
                end
              end else begin
                bit_cnt <= bit_cnt + 4'd1;
              end
            end
          end
          S_RDATA: begin
            if (scl_rise) begin
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                sda_oe    <= 1'b0;
                bit_cnt   <= 4'd0;
                ack_phase <= 1'b0;
                state     <= S_RDATA_ACK;
              end else begin
                sda_oe <= ~rd_byte[bit_idx];
              end
            end
          end
          S_RDATA_ACK: begin
            if (scl_rise) begin
              if (sda_in) begin
                state <= S_IGNORE;
              end else begin
                ack_phase <= 1'b1;
                ptr       <= ptr + 8'd1;
              end
            end else if (scl_fall && ack_phase) begin
              ack_phase <= 1'b0;
              bit_cnt   <= 4'd0;
              state     <= S_RDATA;
              sda_oe    <= ~rd_byte[7];
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mpu6050_i2c_target.sv
`timescale 1ns/1ps
// tb_mpu6050_i2c_target
// Bus-level master driving the target through register writes, reads, bursts,
// address mismatch, aborted bytes and a mid-transfer reset. Expected values
// come from a register-map model kept in this bench.
module tb_mpu6050_i2c_target;

  localparam int Q = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        scl_m = 1'b1;
  logic        sda_m = 1'b1;
  wire         sda;
  logic [15:0] sens [6];
  logic        reg_wr;
  logic [7:0]  reg_wr_addr, reg_wr_data, pwr_mgmt;
  logic        busy;

  int checks = 0;
  int errors = 0;

  assign sda = sda_m ? 1'bz : 1'b0;
  pullup (sda);

  mpu6050_i2c_target dut (
    .clk(clk), .rst(rst), .SCL(scl_m), .SDA(sda),
    .GYROX(sens[3]), .GYROY(sens[4]), .GYROZ(sens[5]),
    .ACCELX(sens[0]), .ACCELY(sens[1]), .ACCELZ(sens[2]),
    .reg_wr(reg_wr), .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data),
    .pwr_mgmt(pwr_mgmt), .busy(busy)
  );

  always #5 clk = ~clk;

  // Register-map model
  logic [7:0]  m_cfg [4];
  logic [7:0]  m_pwr;
  logic [7:0]  m_ptr;
  logic [15:0] m_snap [6];

  function automatic void model_reset();
    foreach (m_cfg[i]) m_cfg[i] = 8'h00;
    m_pwr = 8'h40;
    m_ptr = 8'h00;
  endfunction

  function automatic logic [7:0] model_read(input logic [7:0] a);
    int o;
    if (a >= 8'h19 && a <= 8'h1C) return m_cfg[int'(a) - 'h19];
    if (a >= 8'h3B && a <= 8'h40) begin
      o = int'(a) - 'h3B;
      return (o % 2 == 0) ? m_snap[o / 2][15:8] : m_snap[o / 2][7:0];
    end
    if (a >= 8'h43 && a <= 8'h48) begin
      o = int'(a) - 'h43;
      return (o % 2 == 0) ? m_snap[3 + o / 2][15:8] : m_snap[3 + o / 2][7:0];
    end
    if (a == 8'h6B) return m_pwr;
    if (a == 8'h75) return 8'h68;
    return 8'h00;
  endfunction

  function automatic void model_write(input logic [7:0] a, input logic [7:0] d);
    if (a >= 8'h19 && a <= 8'h1C) m_cfg[int'(a) - 'h19] = d;
    else if (a == 8'h6B) begin
      if (d[7]) begin
        foreach (m_cfg[i]) m_cfg[i] = 8'h00;
        m_pwr = 8'h40;
      end else m_pwr = d;
    end
  endfunction

  // Every observed write strobe, in order
  logic [15:0] wr_obs [$];
  always @(negedge clk) if (reg_wr) wr_obs.push_back({reg_wr_addr, reg_wr_data});

  logic [7:0] rd_q [$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    sda_m = 1'b1; wait_clk(Q);
    scl_m = 1'b1; wait_clk(Q);
    sda_m = 1'b0; wait_clk(Q);
    scl_m = 1'b0; wait_clk(2);
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; wait_clk(Q);
    scl_m = 1'b1; wait_clk(Q);
    sda_m = 1'b1; wait_clk(Q);
  endtask

  task automatic clock_bit(input logic b, output logic s);
    sda_m = b; wait_clk(Q);
    scl_m = 1'b1; wait_clk(Q / 2);
    s = sda; wait_clk(Q / 2);
    scl_m = 1'b0; wait_clk(2);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clock_bit(b[i], s);
    clock_bit(1'b1, s);
    ack = ~s;
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] b);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'b1, s);
      b[i] = s;
    end
    clock_bit(nack, s);
  endtask

  // Write n bytes (data byte i = data[8*i +: 8]) starting at register ra.
  task automatic do_write(input logic [7:0] ra, input logic [31:0] data, input int n);
    logic ack;
    logic [7:0] d;
    logic [15:0] exp_q [$];
    wr_obs.delete();
    bus_start();
    send_byte(8'hD0, ack); check("wr_addr_ack", ack, 1);
    send_byte(ra, ack);    check("wr_reg_ack", ack, 1);
    m_ptr = ra;
    for (int i = 0; i < n; i++) begin
      d = data[8*i +: 8];
      send_byte(d, ack); check("wr_data_ack", ack, 1);
      exp_q.push_back({m_ptr, d});
      model_write(m_ptr, d);
      m_ptr = m_ptr + 8'd1;
    end
    bus_stop();
    check("wr_strobe_count", wr_obs.size(), exp_q.size());
    foreach (exp_q[i]) if (i < wr_obs.size()) check("wr_strobe", wr_obs[i], exp_q[i]);
    check("wr_addr_hold", {reg_wr_addr, reg_wr_data}, exp_q[exp_q.size() - 1]);
    check("pwr_mgmt", pwr_mgmt, m_pwr);
    check("busy_after_wr", busy, 0);
  endtask

  // Set pointer, repeated START, read n bytes (NACK on the last).
  task automatic do_read(input logic [7:0] ra, input int n, input bit change_mid);
    logic ack;
    logic [7:0] b;
    rd_q.delete();
    bus_start();
    send_byte(8'hD0, ack); check("rd_wr_ack", ack, 1);
    send_byte(ra, ack);    check("rd_reg_ack", ack, 1);
    bus_start();
    send_byte(8'hD1, ack); check("rd_addr_ack", ack, 1);
    foreach (m_snap[i]) m_snap[i] = sens[i];
    for (int i = 0; i < n; i++) begin
      read_byte(i == n - 1, b);
      rd_q.push_back(b);
      if (change_mid && i == 0) foreach (sens[k]) sens[k] = 16'($urandom);
    end
    bus_stop();
    m_ptr = ra + 8'(n - 1);
    check("busy_after_rd", busy, 0);
    check("sda_released", sda, 1);
  endtask

  typedef struct {
    bit         rd;
    logic [7:0] ra;
    logic [7:0] val;
    logic [7:0] exp;   // read value, or pwr_mgmt after a write
  } vec_t;

  vec_t vt [14];

  initial begin
    logic [7:0]  ra;
    logic [31:0] rdat;
    logic [47:0] gexp;
    logic        ack, s;
    int          n, nobs;

    vt[0]  = '{1'b0, 8'h1B, 8'h18, 8'h40};
    vt[1]  = '{1'b1, 8'h1B, 8'h00, 8'h18};
    vt[2]  = '{1'b0, 8'h19, 8'h07, 8'h40};
    vt[3]  = '{1'b1, 8'h19, 8'h00, 8'h07};
    vt[4]  = '{1'b1, 8'h75, 8'h00, 8'h68};
    vt[5]  = '{1'b1, 8'h6B, 8'h00, 8'h40};
    vt[6]  = '{1'b0, 8'h6B, 8'h01, 8'h01};
    vt[7]  = '{1'b1, 8'h6B, 8'h00, 8'h01};
    vt[8]  = '{1'b0, 8'h3B, 8'h55, 8'h01};
    vt[9]  = '{1'b1, 8'h20, 8'h00, 8'h00};
    vt[10] = '{1'b0, 8'h6B, 8'hC0, 8'h40};
    vt[11] = '{1'b1, 8'h6B, 8'h00, 8'h40};
    vt[12] = '{1'b1, 8'h1B, 8'h00, 8'h00};
    vt[13] = '{1'b1, 8'h19, 8'h00, 8'h00};

    foreach (sens[i]) sens[i] = 16'h0000;
    model_reset();
    foreach (m_snap[i]) m_snap[i] = 16'h0000;

    wait_clk(5);
    rst = 1'b0;
    wait_clk(3);
    check("rst_sda", sda, 1);
    check("rst_reg_wr", reg_wr, 0);
    check("rst_wr_addr", reg_wr_addr, 8'h00);
    check("rst_wr_data", reg_wr_data, 8'h00);
    check("rst_pwr", pwr_mgmt, 8'h40);
    check("rst_busy", busy, 0);

    // Table-driven register writes and reads
    foreach (vt[i]) begin
      if (vt[i].rd) begin
        do_read(vt[i].ra, 1, 1'b0);
        check($sformatf("vec%0d_read", i), rd_q[0], vt[i].exp);
      end else begin
        do_write(vt[i].ra, {24'h0, vt[i].val}, 1);
        check($sformatf("vec%0d_pwr", i), pwr_mgmt, vt[i].exp);
      end
    end

    // Gyro burst with inputs changing after the first byte
    sens[3] = 16'h1234; sens[4] = 16'hABCD; sens[5] = 16'h8001;
    gexp = 48'h1234ABCD8001;
    do_read(8'h43, 6, 1'b1);
    for (int i = 0; i < 6; i++) check($sformatf("gyro_burst%0d", i), rd_q[i], gexp[47 - 8*i -: 8]);

    // Address 0x69: NACK and everything after it ignored
    wr_obs.delete();
    bus_start();
    send_byte(8'hD2, ack); check("nack_addr", ack, 0);
    send_byte(8'h1B, ack); check("nack_follow", ack, 0);
    check("busy_ignored", busy, 1);
    bus_stop();
    check("busy_after_nack", busy, 0);
    check("nack_no_write", wr_obs.size(), 0);

    // START in the middle of a data byte discards it
    wr_obs.delete();
    bus_start();
    send_byte(8'hD0, ack);
    send_byte(8'h1C, ack);
    for (int i = 0; i < 4; i++) clock_bit(1'b1, s);
    bus_start();
    send_byte(8'hD0, ack); check("restart_ack", ack, 1);
    bus_stop();
    nobs = wr_obs.size();
    check("start_midbyte_no_write", nobs, 0);
    do_read(8'h1C, 1, 1'b0);
    check("start_midbyte_reg", rd_q[0], model_read(8'h1C));

    // STOP in the middle of a data byte discards it
    wr_obs.delete();
    bus_start();
    send_byte(8'hD0, ack);
    send_byte(8'h19, ack);
    for (int i = 0; i < 3; i++) clock_bit(1'b0, s);
    bus_stop();
    check("stop_midbyte_busy", busy, 0);
    check("stop_midbyte_sda", sda, 1);
    check("stop_midbyte_no_write", wr_obs.size(), 0);

    // Reset during bit 4 of a read byte (0x6B = 0x40, so that bit drives low)
    do_write(8'h6B, 32'h80, 1);
    bus_start();
    send_byte(8'hD0, ack);
    send_byte(8'h6B, ack);
    bus_start();
    send_byte(8'hD1, ack); check("rst_rd_addr_ack", ack, 1);
    for (int i = 0; i < 3; i++) clock_bit(1'b1, s);
    wait_clk(4);
    check("rst_pre_sda_low", sda, 0);
    rst = 1'b1;
    wait_clk(1);
    check("rst_mid_sda", sda, 1);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_pwr", pwr_mgmt, 8'h40);
    rst = 1'b0;
    scl_m = 1'b1;
    sda_m = 1'b1;
    wait_clk(Q);
    model_reset();
    do_write(8'h1A, 32'h03, 1);
    do_read(8'h1A, 1, 1'b0);
    check("post_rst_readback", rd_q[0], 8'h03);

    // Randomized writes and reads against the model
    for (int it = 0; it < 12; it++) begin
      if ($urandom_range(1, 0) == 1) begin
        case ($urandom_range(4, 0))
          0:       ra = 8'h19 + 8'($urandom_range(3, 0));
          1:       ra = 8'h6B;
          2:       ra = 8'hFF;
          3:       ra = 8'h3B;
          default: ra = 8'($urandom);
        endcase
        n = $urandom_range(3, 1);
        rdat = $urandom;
        do_write(ra, rdat, n);
        do_read(ra, 1, 1'b0);
        check("rnd_wr_readback", rd_q[0], model_read(ra));
      end else begin
        foreach (sens[k]) sens[k] = 16'($urandom);
        case ($urandom_range(4, 0))
          0:       ra = 8'h3B + 8'($urandom_range(5, 0));
          1:       ra = 8'h43 + 8'($urandom_range(5, 0));
          2:       ra = 8'h19;
          3:       ra = 8'hFE;
          default: ra = 8'($urandom);
        endcase
        n = $urandom_range(6, 1);
        do_read(ra, n, 1'($urandom_range(1, 0)));
        for (int i = 0; i < n; i++) check($sformatf("rnd_rd_%0h", ra + 8'(i)), rd_q[i], model_read(ra + 8'(i)));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
